omux_arbiter: RTL and testbench
===============================

# omux_arbiter

Round-robin arbiter sharing one byte-wide output stream between `NREQ` record buffers that expose the `omux_req`/`omux_sel`/`omux_data` handshake. It grants one requester at a time and holds the grant for a whole record of `REC_BYTES` bytes, so records never interleave. Selected bytes go through a single register stage into the downstream byte FIFO write port, for example the host-interface FIFO. It also keeps counts of completed and aborted records for status readout.

## Interface
- `NREQ`, 4 — number of requesters, at least 2.
- `REC_BYTES`, 16 — bytes per record. Must equal the requesters' `WIDTH/8`.
- `CNT_WIDTH`, 16 — width of the statistics counters.

- `clk_i`  in  1  — single clock; every register is on its rising edge.
- `rst_n_i`  in  1  — reset, asynchronous and active-low.
- `req_i`  in  NREQ  — per-requester `omux_req`. Bit k belongs to requester k.
- `sel_o`  out  NREQ  — per-requester `omux_sel`. One-hot or zero.
- `data_i`  in  NREQ*8  — requester k's byte on `data_i[8k+7:8k]`. Only meaningful while `sel_o[k]` is high.
- `out_full_i`  in  1  — downstream almost-full. Must leave at least 1 entry of slack.
- `out_wr_o`  out  1  — downstream write strobe, one byte per high cycle.
- `out_data_o`  out  8  — downstream write data.
- `busy_o`  out  1  — high in ARM or XFER.
- `rec_count_o`  out  CNT_WIDTH  — completed records, wraps.
- `abort_count_o`  out  CNT_WIDTH  — aborted records, wraps.

## Operation
- **Reset values.** While `rst_n_i` is low:
  - state = IDLE; `sel_o`, `out_wr_o`, `out_data_o`, `busy_o` and both counters are 0.
  - Priority pointer `last` = NREQ-1, so requester 0 has first priority after reset.
- **Reset mid-operation.** Takes effect immediately. Any partial record is discarded, and `abort_count_o` is not incremented.
- **IDLE.**
  - If any `req_i` bit is high, pick the first set bit scanning `last+1, last+2, …` modulo NREQ.
  - Latch the winner as `cur`, set `last` = winner, go to ARM.
  - Otherwise stay in IDLE.
- **ARM.** Lasts one cycle with `sel_o` = 0. This gives the requester time to latch its record.
  - If `req_i[cur]` is high: clear the byte counter `pos` to 0 and go to XFER.
  - Otherwise go to IDLE with no count change.
- **XFER.**
  - `sel_o[cur]` = `req_i[cur] & ~out_full_i`, computed combinationally from current inputs.
  - Each cycle `sel_o[cur]` is high is one byte transfer; `pos` increments.
  - When the transfer that makes `pos` equal `REC_BYTES` occurs: increment `rec_count_o` and go to IDLE.
  - If `req_i[cur]` is low at any cycle of XFER (requester buffer emptied): go to IDLE, increment `abort_count_o`, and write no padding bytes.
  - `out_full_i` high with `req_i[cur]` high: stall in XFER with `sel_o` = 0. This is not an abort.
- **Width rules.**
  - `pos` is `$clog2(REC_BYTES)+1` bits wide, so it can reach `REC_BYTES` without overflow.
  - `last` and `cur` are `$clog2(NREQ)` bits; the round-robin scan wraps modulo NREQ.
- **Fairness.** A requester that just finished gets lowest priority in the next arbitration. Any requester holding `req_i` high is granted within NREQ-1 other records.

## Timing
- **Output register.** If `sel_o[k]` is high in cycle t, then in cycle t+1 `out_wr_o` = 1 and `out_data_o` = `data_i[8k+7:8k]` as sampled at t.
- **Strobe width.** `out_wr_o` is high for exactly one cycle per transfer.
- **Downstream slack.** `out_full_i` sampled at t stops the byte at t. A byte already selected at t-1 is still written at t; the 1-entry slack absorbs it.
- **Grant latency.** If `req_i` rises in cycle t while in IDLE, the first possible `sel_o` is at t+2 (IDLE at t, ARM at t+1).
- **Gap between records.** At least 2 cycles with `sel_o` = 0 between the last byte of one record and the first byte of the next, from any requester. This matches the requesters' record-reload cycle.
- **Counter update.** `rec_count_o` and `abort_count_o` update on the clock edge that leaves XFER.
- **Sustained rate.** With no back-pressure: REC_BYTES bytes per REC_BYTES+2 cycles.
- **Simultaneous events.** Last-byte completion and `req_i[cur]` falling in the same cycle count as completion, not abort.

## Test plan
- **Single requester.** `req_i` = 0001 steady, `out_full_i` = 0, REC_BYTES = 16, bytes 0x00..0x0F → 16 `out_wr_o` pulses carrying 0x00..0x0F in order, then 2 cycles with `sel_o` = 0, then the next record; `rec_count_o` = 1 after the first record.
- **Round robin.** `req_i` = 1111 held → grant order 0,1,2,3,0; no bytes from two requesters interleave; `rec_count_o` = 5 after 5 records.
- **Back-pressure.** `out_full_i` high for 3 cycles in the middle of a record → `sel_o` low during exactly those 3 cycles, no byte lost or duplicated, 16 bytes total for the record.
- **Abort.** `req_i[2]` dropped after 5 bytes → return to IDLE, `abort_count_o` = 1, `rec_count_o` unchanged, no further writes from requester 2 until it requests again.
- **Reset mid-record.** `rst_n_i` pulsed low during byte 7 → outputs are 0 asynchronously; after release the first grant goes to requester 0 and both counters read 0.

Source files
------------

// File: rtl/omux_arbiter.sv
// Round-robin arbiter that muxes whole records from NREQ byte-stream buffers
// into one registered downstream FIFO write port, with record/abort statistics.
module omux_arbiter #(
  parameter int NREQ      = 4,
  parameter int REC_BYTES = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NREQ-1:0]      req_i,
  output logic [NREQ-1:0]      sel_o,
  input  logic [NREQ*8-1:0]    data_i,
  input  logic                 out_full_i,
  output logic                 out_wr_o,
  output logic [7:0]           out_data_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] rec_count_o,
  output logic [CNT_WIDTH-1:0] abort_count_o
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int POS_W = $clog2(REC_BYTES) + 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(REC_BYTES - 1);

  typedef enum logic [1:0] {IDLE, ARM, XFER} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [CNT_WIDTH-1:0] rec_q, rec_d;
  logic [CNT_WIDTH-1:0] abort_q, abort_d;
  logic                 wr_q;
  logic [7:0]           data_q;
  logic                 xfer;
  logic [7:0]           cur_byte;

  // Scan last+1, last+2, ... modulo NREQ; descending loop lets the nearest hit win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    win = last;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NREQ);
      if (req[cand]) win = cand;
    end
    return win;
  endfunction

  assign cur_byte = data_i[{cur_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    pos_d   = pos_q;
    rec_d   = rec_q;
    abort_d = abort_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          cur_d   = rr_pick(req_i, last_q);
          last_d  = cur_d;
          state_d = ARM;
        end
      end
      ARM: begin
        if (req_i[cur_q]) begin
          pos_d   = '0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (!req_i[cur_q]) begin
          abort_d = abort_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end else if (!out_full_i) begin
          xfer  = 1'b1;
          pos_d = pos_q + POS_W'(1);
          if (pos_q == LAST_POS) begin
            rec_d   = rec_q + CNT_WIDTH'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_o = '0;
    if (xfer) sel_o[cur_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      pos_q   <= '0;
      rec_q   <= '0;
      abort_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      pos_q   <= pos_d;
      rec_q   <= rec_d;
      abort_q <= abort_d;
      wr_q    <= xfer;
      if (xfer) data_q <= cur_byte;
    end
  end

  assign out_wr_o      = wr_q;
  assign out_data_o    = data_q;
  assign busy_o        = (state_q != IDLE);
  assign rec_count_o   = rec_q;
  assign abort_count_o = abort_q;

endmodule

// File: tb/tb_omux_arbiter.sv
// Bench for omux_arbiter: cycle vector table, directed record/abort/reset
// sequences, and randomized back-pressure against a record-level stream model.
module tb_omux_arbiter;
  localparam int NREQ = 4;
  localparam int RB   = 16;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, sel;
  logic [NREQ*8-1:0] data;
  logic              full, wr, busy;
  logic [7:0]        odata;
  logic [CW-1:0]     rec_cnt, abort_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  omux_arbiter #(.NREQ(NREQ), .REC_BYTES(RB), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .sel_o(sel), .data_i(data),
    .out_full_i(full), .out_wr_o(wr), .out_data_o(odata), .busy_o(busy),
    .rec_count_o(rec_cnt), .abort_count_o(abort_cnt)
  );

  // Requester buffers: byte = {id, record number, position}; a dropped request
  // discards the partial record.
  int rpos [NREQ] = '{default: 0};
  int rrec [NREQ] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NREQ; k++) begin
      if (!rst_n || !req[k]) rpos[k] <= 0;
      else if (sel[k]) begin
        if (rpos[k] == RB - 1) begin
          rpos[k] <= 0;
          rrec[k] <= rrec[k] + 1;
        end else begin
          rpos[k] <= rpos[k] + 1;
        end
      end
    end
  end

  always_comb begin
    data = '0;
    for (int k = 0; k < NREQ; k++)
      data[k*8 +: 8] = {2'(k), 2'(rrec[k]), 4'(rpos[k])};
  end

  logic [7:0] obs_q [$];
  logic [7:0] exp_q [$];
  int viol = 0;

  always @(negedge clk) begin
    if (wr) obs_q.push_back(odata);
    if (full && sel != '0) viol++;
    if ($countones(sel) > 1) viol++;
  end

  int m_rec [NREQ] = '{default: 0};
  int last_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_next(input logic [NREQ-1:0] mask, input int last);
    int j;
    for (int i = 1; i <= NREQ; i++) begin
      j = (last + i) % NREQ;
      if (mask[j[1:0]]) return j;
    end
    return last;
  endfunction

  task automatic push_record(input int k, input int nbytes, input bit done);
    for (int p = 0; p < nbytes; p++) exp_q.push_back({2'(k), 2'(m_rec[k]), 4'(p)});
    if (done) m_rec[k]++;
  endtask

  task automatic compare_stream(input string name);
    int bad;
    checks++;
    bad = -1;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s: got %0d bytes expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++)
        if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s: byte %0d got %0h expected %0h", name, bad, obs_q[bad], exp_q[bad]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] sel;
    logic       busy;
    logic       wr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int cyc [$];
    int order [5];
    int exp_rec, mask, nrec, w, cnt;

    tbl[0] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0};  // IDLE, grant 0
    tbl[1] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};  // ARM
    tbl[2] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};  // byte 0
    tbl[3] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1};  // stall, byte 0 written
    tbl[4] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[5] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[6] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};  // byte 1
    tbl[7] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1};  // request drops -> abort
    tbl[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

    rst_n = 1'b0; req = '0; full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", sel, 0);
    check("rst_wr", wr, 0);
    check("rst_data", odata, 0);
    check("rst_busy", busy, 0);
    check("rst_rec", rec_cnt, 0);
    check("rst_abort", abort_cnt, 0);
    rst_n = 1'b1;
    last_m = NREQ - 1;
    tick();

    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req; full = tbl[i].full;
      #1;
      check($sformatf("vec%0d_sel", i), sel, tbl[i].sel);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("vec%0d_wr", i), wr, tbl[i].wr);
      tick();
    end
    check("vec_abort", abort_cnt, 1);
    check("vec_rec", rec_cnt, 0);
    last_m = 0;
    push_record(0, 2, 1'b0);
    compare_stream("vec_stream");

    // Single requester, two back-to-back records.
    req = 4'b0001;
    for (int i = 0; i < 37; i++) begin
      if (i == 36) req = '0;
      #1;
      if (sel != '0) cyc.push_back(i);
      tick();
    end
    check("single_nsel", cyc.size(), 32);
    if (cyc.size() == 32) begin
      check("single_first", cyc[0], 2);
      check("single_gap", cyc[16] - cyc[15], 3);
    end
    check("single_rec", rec_cnt, 2);
    push_record(0, RB, 1'b1);
    push_record(0, RB, 1'b1);
    compare_stream("single_stream");

    // Reset during byte 7 of requester 2.
    req = 4'b0100;
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_sel", sel, 4'b0100);
    check("pre_rst_wr", wr, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", sel, 0);
    check("mid_rst_wr", wr, 0);
    check("mid_rst_data", odata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rec", rec_cnt, 0);
    check("mid_rst_abort", abort_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    last_m = NREQ - 1;

    // Round robin with every requester active.
    req = 4'b1111;
    for (int i = 0; i < 91; i++) begin
      if (i == 90) req = '0;
      tick();
    end
    order = '{0, 1, 2, 3, 0};
    if (obs_q.size() >= 5 * RB)
      for (int r = 0; r < 5; r++) check($sformatf("rr_order%0d", r), obs_q[r*RB][7:6], order[r]);
    for (int r = 0; r < 5; r++) begin
      w = rr_next(4'b1111, last_m);
      push_record(w, RB, 1'b1);
      last_m = w;
    end
    compare_stream("rr_stream");
    check("rr_rec", rec_cnt, 5);

    // Requester 2 empties after 5 bytes.
    req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) req = '0;
      tick();
    end
    repeat (5) tick();
    check("abort_cnt", abort_cnt, 1);
    check("abort_rec", rec_cnt, 5);
    check("abort_busy", busy, 0);
    last_m = 2;
    push_record(2, 5, 1'b0);
    compare_stream("abort_stream");

    // Random requester sets with random back-pressure.
    exp_rec = 5;
    for (int ph = 0; ph < 8; ph++) begin
      mask = $urandom_range(1, 15);
      nrec = $urandom_range(1, 3);
      for (int r = 0; r < nrec; r++) begin
        w = rr_next(4'(mask), last_m);
        push_record(w, RB, 1'b1);
        last_m = w;
      end
      exp_rec += nrec;
      req = 4'(mask);
      cnt = 0;
      while (rec_cnt != CW'(exp_rec) && cnt < 300 * nrec) begin
        full = ($urandom_range(0, 3) == 0);
        tick();
        cnt++;
      end
      req = '0; full = 1'b0;
      check($sformatf("rand%0d_rec", ph), rec_cnt, exp_rec);
      repeat (3) tick();
      compare_stream($sformatf("rand%0d_stream", ph));
    end
    check("rand_abort", abort_cnt, 1);
    check("protocol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
